// File: rtl/writeback_scoreboard_pkg.sv
// writeback_scoreboard_pkg: shared writeback classes, register ids and slot format
package writeback_scoreboard_pkg;
  localparam int SLOTS = 32;
  localparam int NREG = 64;
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_GPR = 2'b01;
  localparam logic [1:0] RW_FPR = 2'b10;
  typedef logic [5:0] regid_t;
  typedef struct packed {
    logic valid;
    logic [1:0] rw;
    logic [4:0] rd;
  } wb_slot_t;
endpackage

// File: rtl/writeback_scoreboard_ring.sv
// wb_slot_ring: circular writeback reservation ring indexed by a free-running head
module wb_slot_ring
  import writeback_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic reserve_en,
  input  logic [4:0] reserve_idx,
  input  wb_slot_t reserve_entry,
  output wb_slot_t head_entry,
  output logic collision,
  output logic [4:0] head
);
  wb_slot_t ring [SLOTS];
  assign head_entry = ring[head];
  assign collision = ring[reserve_idx].valid;
  // Reservations never target head (wait >= 1), so clear and write cannot meet.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      for (int i = 0; i < SLOTS; i++) ring[i] <= '0;
    end else begin
      head <= head + 5'd1;
      ring[head] <= '0;
      if (reserve_en) ring[reserve_idx] <= reserve_entry;
    end
  end
endmodule

// File: rtl/writeback_scoreboard.sv
// writeback_scoreboard: reserves writeback slots, tracks pending registers, drives regfile writes
module writeback_scoreboard
  import writeback_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic issue_valid,
  input  logic [1:0] issue_rw,
  input  logic [4:0] issue_rd,
  input  logic [4:0] issue_wait,
  input  logic [5:0] src_s,
  input  logic src_s_used,
  input  logic [5:0] src_t,
  input  logic src_t_used,
  output logic stall,
  input  logic res_valid,
  input  logic [31:0] res_data,
  output logic [1:0] rw_out,
  output logic [4:0] rd_out,
  output logic [31:0] d_out,
  output logic err_missing,
  output logic err_orphan
);
  logic [4:0] cnt [NREG];
  logic [4:0] w, head, slot_idx;
  regid_t dest;
  logic has_dest, collision, hazard, accept, hit;
  wb_slot_t head_entry;
  assign w = (issue_wait == 5'd0) ? 5'd1 : issue_wait;
  assign dest = {issue_rw[1], issue_rd};
  assign has_dest = issue_rw != RW_NONE;
  assign slot_idx = head + w;
  assign hazard = (src_s_used && cnt[src_s] != 5'd0) || (src_t_used && cnt[src_t] != 5'd0) ||
                  (has_dest && (cnt[dest] != 5'd0 || collision));
  assign stall = issue_valid && hazard;
  assign accept = issue_valid && !hazard && has_dest;
  assign hit = head_entry.valid && res_valid;
  wb_slot_ring u_ring (
    .clk(clk),
    .rst(rst),
    .reserve_en(accept),
    .reserve_idx(slot_idx),
    .reserve_entry({1'b1, issue_rw, issue_rd}),
    .head_entry(head_entry),
    .collision(collision),
    .head(head)
  );
  // Register id 0 is hardwired zero: its slot is written but it never blocks readers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      rw_out <= RW_NONE;
      rd_out <= '0;
      d_out <= '0;
      err_missing <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++)
        cnt[i] <= (accept && dest == regid_t'(i) && dest != '0) ? w :
                  (cnt[i] != 5'd0) ? cnt[i] - 5'd1 : 5'd0;
      rw_out <= hit ? head_entry.rw : RW_NONE;
      rd_out <= hit ? head_entry.rd : rd_out;
      d_out <= hit ? res_data : d_out;
      err_missing <= err_missing | (head_entry.valid && !res_valid);
      err_orphan <= err_orphan | (!head_entry.valid && res_valid);
    end
  end
endmodule

// File: tb/tb_writeback_scoreboard.sv
// tb_writeback_scoreboard: directed stimulus with a queued expected-writeback scoreboard
module tb_writeback_scoreboard;
  import writeback_scoreboard_pkg::*;
  logic clk = 0, rst = 1, issue_valid = 0;
  logic [1:0] issue_rw = 0;
  logic [4:0] issue_rd = 0, issue_wait = 0;
  logic [5:0] src_s = 0, src_t = 0;
  logic src_s_used = 0, src_t_used = 0, stall, res_valid = 0;
  logic [31:0] res_data = 0;
  logic [1:0] rw_out;
  logic [4:0] rd_out;
  logic [31:0] d_out;
  logic err_missing, err_orphan;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct {logic [1:0] rw; logic [4:0] rd; logic [31:0] d; int due;} exp_t;
  typedef struct {int at; logic [31:0] d;} res_t;
  exp_t exp_q[$];
  res_t res_q[$];
  exp_t m_e;

  writeback_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rw(issue_rw), .issue_rd(issue_rd),
    .issue_wait(issue_wait), .src_s(src_s), .src_s_used(src_s_used), .src_t(src_t),
    .src_t_used(src_t_used), .stall(stall), .res_valid(res_valid), .res_data(res_data),
    .rw_out(rw_out), .rd_out(rd_out), .d_out(d_out), .err_missing(err_missing),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [1:0] rw, logic [4:0] rd, logic [4:0] w,
                       logic [5:0] s, logic su, logic [5:0] t, logic tu);
    issue_valid = v; issue_rw = rw; issue_rd = rd; issue_wait = w;
    src_s = s; src_s_used = su; src_t = t; src_t_used = tu;
  endtask

  task automatic idle();
    drive(0, RW_NONE, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic sched_res(int at, logic [31:0] d);
    res_t r;
    int k = 0;
    r.at = at; r.d = d;
    while (k < res_q.size() && res_q[k].at <= at) k++;
    res_q.insert(k, r);
  endtask

  // Expected write appears w+1 cycles after issue; the result pulse is planned one cycle earlier.
  task automatic expect_wb(logic [1:0] rw, logic [4:0] rd, int w, logic [31:0] d);
    exp_t e;
    int k = 0;
    int wn = (w == 0) ? 1 : w;
    e.rw = rw; e.rd = rd; e.d = d; e.due = cyc + wn + 1;
    while (k < exp_q.size() && exp_q[k].due <= e.due) k++;
    exp_q.insert(k, e);
    sched_res(cyc + wn, d);
  endtask

  always @(posedge clk) begin
    #1;
    if (res_q.size() != 0 && res_q[0].at == cyc) begin
      res_valid = 1; res_data = res_q[0].d;
      void'(res_q.pop_front());
    end else begin
      res_valid = 0; res_data = 0;
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
      checks++; errors++;
      $display("FAIL wb_missed: no write for rd=%0d due cycle %0d (now %0d)", exp_q[0].rd, exp_q[0].due, cyc);
      void'(exp_q.pop_front());
    end
    if (rw_out !== RW_NONE) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected: rw=%b rd=%0d d=%h with nothing expected (cycle %0d)", rw_out, rd_out, d_out, cyc);
      end else begin
        m_e = exp_q.pop_front();
        chk("wb_rw", 32'(rw_out), 32'(m_e.rw));
        chk("wb_rd", 32'(rd_out), 32'(m_e.rd));
        chk("wb_data", d_out, m_e.d);
        chk("wb_cycle", cyc, m_e.due);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, n;
    repeat (2) step();
    rst = 0;
    chk("rst_rw_out", 32'(rw_out), 0);
    chk("rst_err_missing", 32'(err_missing), 0);
    chk("rst_err_orphan", 32'(err_orphan), 0);
    drive(1, RW_NONE, 0, 0, 6'd5, 1, 6'd40, 1);
    #1 chk("rst_stall", 32'(stall), 0);
    step();
    // basic GPR writeback
    drive(1, RW_GPR, 5, 4, 0, 0, 0, 0);
    #1 chk("s1_stall", 32'(stall), 0);
    expect_wb(RW_GPR, 5, 4, 32'hDEADBEEF);
    step(); idle();
    repeat (6) step();
    chk("s1_err_missing", 32'(err_missing), 0);
    chk("s1_err_orphan", 32'(err_orphan), 0);
    // RAW stall until the producing write
    drive(1, RW_GPR, 5, 6, 0, 0, 0, 0);
    #1 chk("s2_stall", 32'(stall), 0);
    expect_wb(RW_GPR, 5, 6, 32'h11112222);
    c0 = cyc;
    step();
    drive(1, RW_NONE, 0, 0, 6'd5, 1, 0, 0);
    n = 0;
    while (n < 20) begin
      #1;
      if (!stall) break;
      n++;
      step();
    end
    chk("s2_stall_cycles", n, 6);
    chk("s2_accept_cycle", cyc - c0, 7);
    chk("s2_rw_now", 32'(rw_out), 32'(RW_GPR));
    step(); idle();
    repeat (3) step();
    // slot collision
    drive(1, RW_GPR, 7, 4, 0, 0, 0, 0);
    #1 chk("s3_a_stall", 32'(stall), 0);
    expect_wb(RW_GPR, 7, 4, 32'hAAAA0007);
    step();
    drive(1, RW_GPR, 8, 3, 0, 0, 0, 0);
    #1 chk("s3_collide", 32'(stall), 1);
    step();
    #1 chk("s3_retry", 32'(stall), 0);
    expect_wb(RW_GPR, 8, 3, 32'hBBBB0008);
    step(); idle();
    repeat (6) step();
    // FPR with maximum wait, wrapping the ring
    drive(1, RW_FPR, 2, 31, 0, 0, 0, 0);
    #1 chk("s4_stall", 32'(stall), 0);
    expect_wb(RW_FPR, 2, 31, 32'hF00D0002);
    step();
    drive(1, RW_FPR, 2, 1, 0, 0, 0, 0);
    #1 chk("s4_waw", 32'(stall), 1);
    step();
    drive(1, RW_NONE, 0, 0, 6'd34, 1, 0, 0);
    #1 chk("s4_raw_fpr", 32'(stall), 1);
    drive(1, RW_NONE, 0, 0, 6'd2, 1, 0, 0);
    #1 chk("s4_gpr2_free", 32'(stall), 0);
    step(); idle();
    repeat (33) step();
    // wait 0 behaves as 1, register 0 never busy, forwarding-cycle issue
    drive(1, RW_GPR, 10, 0, 0, 0, 0, 0);
    #1 chk("s5_w0_stall", 32'(stall), 0);
    expect_wb(RW_GPR, 10, 0, 32'h00005A5A);
    step();
    drive(1, RW_GPR, 0, 3, 0, 0, 0, 0);
    #1 chk("s5_zero_stall", 32'(stall), 0);
    expect_wb(RW_GPR, 0, 3, 32'h00000ABC);
    step();
    drive(1, RW_NONE, 0, 0, 6'd0, 1, 6'd10, 1);
    #1 chk("s5_zero_free", 32'(stall), 0);
    step(); idle();
    repeat (6) step();
    // orphan result and missing result
    chk("s6_orphan_pre", 32'(err_orphan), 0);
    sched_res(cyc + 1, 32'h0BADF00D);
    repeat (2) step();
    chk("s6_orphan", 32'(err_orphan), 1);
    repeat (3) step();
    chk("s6_orphan_sticky", 32'(err_orphan), 1);
    chk("s6_missing_pre", 32'(err_missing), 0);
    drive(1, RW_GPR, 9, 2, 0, 0, 0, 0);
    step(); idle();
    repeat (2) step();
    chk("s6_missing", 32'(err_missing), 1);
    chk("s6_missing_rw", 32'(rw_out), 0);
    repeat (2) step();
    // reset with reservations in flight
    c0 = cyc;
    drive(1, RW_GPR, 11, 10, 0, 0, 0, 0);
    step();
    drive(1, RW_GPR, 12, 11, 0, 0, 0, 0);
    step();
    drive(1, RW_FPR, 13, 12, 0, 0, 0, 0);
    step(); idle();
    rst = 1;
    step();
    rst = 0;
    chk("s7_rw_out", 32'(rw_out), 0);
    chk("s7_err_missing", 32'(err_missing), 0);
    chk("s7_err_orphan", 32'(err_orphan), 0);
    drive(1, RW_NONE, 0, 0, 6'd11, 1, 6'd45, 1);
    #1 chk("s7_stall", 32'(stall), 0);
    sched_res(c0 + 10, 32'h1A7E0011);
    step(); idle();
    while (cyc < c0 + 12) step();
    chk("s7_late_orphan", 32'(err_orphan), 1);
    repeat (3) step();
    chk("exp_queue_empty", exp_q.size(), 0);
    chk("res_queue_empty", res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
